// File: rtl/fft_addr_ctrl.sv
// Address sequencer for an in-place radix-2 FFT: walks stage/butterfly indices,
// inserts a datapath flush gap between stages and reports completion.
module fft_addr_ctrl #(
  parameter int R   = 5,
  parameter int LAT = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_stall,
  output logic         o_busy,
  output logic         o_valid,
  output logic [3:0]   o_c,
  output logic [R-2:0] o_b,
  output logic         o_s,
  output logic [R-2:0] o_tw,
  output logic         o_last,
  output logic         o_done
);

  localparam int BW = R - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      c_q, c_d;
  logic [BW-1:0]   b_q, b_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BW-1:0]   tw_mask;
  logic [3:0]      tw_shift;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          c_d     = '0;
          b_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (!i_stall) begin
          if (b_q == {BW{1'b1}}) begin
            state_d = FLUSH;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // The gap only counts cycles in which the datapath actually advanced.
        if (!i_stall) begin
          if (cnt_q == 4'(LAT - 1)) begin
            cnt_d = '0;
            if (c_q == 4'(R - 1)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
              c_d     = c_q + 1'b1;
              b_d     = '0;
              valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        c_d     = '0;
        b_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Low c bits of b move to the top of the exponent; wraps to all-ones at c = R-1.
  always_comb begin
    tw_mask  = (BW'(1) << c_q) - BW'(1);
    tw_shift = 4'(BW) - c_q;
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_c     = c_q;
  assign o_b     = b_q;
  assign o_s     = ^b_q;
  assign o_tw    = (b_q & tw_mask) << tw_shift;
  assign o_last  = valid_q & (b_q == {BW{1'b1}});
  assign o_done  = done_q;

endmodule
